// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the NPC memory-port arbiter.
// Holds FSM states, requester ids and default widths.
package npc_mem_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 255;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker, purely combinational.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
    import npc_mem_pkg::*;
(
    input  logic    ifu_valid_i,
    input  logic    lsu_valid_i,
    input  req_id_e last_grant_i,
    output logic [1:0] gnt_o,
    output req_id_e gnt_id_o
);

    // Pick the winner, then expand it to a one-hot grant
    always_comb begin
        gnt_id_o = REQ_IFU;
        if (ifu_valid_i && lsu_valid_i) begin
            if (last_grant_i == REQ_IFU) gnt_id_o = REQ_LSU;
        end else if (lsu_valid_i) begin
            gnt_id_o = REQ_LSU;
        end
        gnt_o[0] = (ifu_valid_i || lsu_valid_i) && (gnt_id_o == REQ_IFU);
        gnt_o[1] = (ifu_valid_i || lsu_valid_i) && (gnt_id_o == REQ_LSU);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time.
// Round-robin grant, request/response handshake, timeout abort with error.
module mem_port_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_req_ready,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_req_ready,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int MASK_W = DATA_W / 8;
    // Last WAIT cycle: the counter would reach TIMEOUT_CYC on the next edge
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    state_e              state_q, state_d;
    req_id_e             owner_q, owner_d;
    req_id_e             last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                ifu_err_q, ifu_err_d;
    logic                lsu_err_q, lsu_err_d;

    logic [1:0]          gnt;
    req_id_e             gnt_id;
    logic                fin;
    logic [DATA_W-1:0]   fin_data;
    logic                fin_err;

    rr_arb2 u_arb (
        .ifu_valid_i  (ifu_req_valid),
        .lsu_valid_i  (lsu_req_valid),
        .last_grant_i (last_q),
        .gnt_o        (gnt),
        .gnt_id_o     (gnt_id)
    );

    // Next-state logic for the transaction FSM and its latched fields
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        ifu_err_d   = ifu_err_q;
        lsu_err_d   = lsu_err_q;
        fin         = 1'b0;
        fin_data    = mem_rdata;
        fin_err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = REQ;
                    owner_d = gnt_id;
                    last_d  = gnt_id;
                    if (gnt_id == REQ_IFU) begin
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '1;
                    end else begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    fin = 1'b1;
                end else if (cnt_q >= CNT_LAST) begin
                    fin      = 1'b1;
                    fin_data = DATA_W'(ERR_DATA);
                    fin_err  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (fin) begin
                    state_d = RESP;
                    if (owner_q == REQ_IFU) begin
                        ifu_rdata_d = fin_data;
                        ifu_err_d   = fin_err;
                    end else begin
                        lsu_rdata_d = fin_data;
                        lsu_err_d   = fin_err;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= REQ_IFU;
            last_q      <= REQ_LSU;
            cnt_q       <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            ifu_err_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            ifu_err_q   <= ifu_err_d;
            lsu_err_q   <= lsu_err_d;
        end
    end

    assign ifu_req_ready  = (state_q == IDLE) && gnt[0];
    assign lsu_req_ready  = (state_q == IDLE) && gnt[1];
    assign mem_req_valid  = (state_q == REQ);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign ifu_resp_valid = (state_q == RESP) && (owner_q == REQ_IFU);
    assign lsu_resp_valid = (state_q == RESP) && (owner_q == REQ_LSU);
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign ifu_resp_err   = ifu_err_q;
    assign lsu_resp_err   = lsu_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed vectors, a grant table and randomized transactions vs a model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_addr;
    logic        ifu_req_ready;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    logic        lsu_req_valid;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_addr       (ifu_addr),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: who won last, and what each requester last received
    bit          m_last;
    logic [31:0] m_ifu_rd;
    logic [31:0] m_lsu_rd;

    typedef struct {
        bit          iv;
        bit          lv;
        int          exp_owner;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs;
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic do_reset;
        clr_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_last   = 1'b1;
        m_ifu_rd = '0;
        m_lsu_rd = '0;
    endtask

    task automatic chk_zero_outs(input string nm);
        chk({nm, "_flags"},
            {30'd0, ifu_resp_valid, lsu_resp_valid} |
            {28'd0, ifu_resp_err, lsu_resp_err, mem_req_valid, mem_wen},
            32'd0);
        chk({nm, "_addr"}, mem_addr, 32'd0);
        chk({nm, "_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_wmask"}, {28'd0, mem_wmask}, 32'd0);
        chk({nm, "_ifu_rdata"}, ifu_rdata, 32'd0);
        chk({nm, "_lsu_rdata"}, lsu_rdata, 32'd0);
    endtask

    // One full transaction; resp_dly < 0 means memory never answers
    task automatic do_txn(input bit iv, input bit lv,
                          input logic [31:0] ia, input logic [31:0] la,
                          input bit lw, input logic [31:0] lwd,
                          input logic [3:0] lm, input int rdy_dly,
                          input int resp_dly, input logic [31:0] rd,
                          input bit junk, output int owner);
        bit          own;
        logic [31:0] ea, ewd, erd;
        logic        ew, eerr;
        logic [3:0]  em;
        int          n;
        own = (iv && lv) ? ~m_last : lv;
        ifu_req_valid = iv;
        ifu_addr      = ia;
        lsu_req_valid = lv;
        lsu_addr      = la;
        lsu_wen       = lw;
        lsu_wdata     = lwd;
        lsu_wmask     = lm;
        #1;
        owner = (ifu_req_ready && lsu_req_ready) ? 3 :
                ifu_req_ready ? 0 : lsu_req_ready ? 1 : 2;
        chk("ifu_req_ready", {31'd0, ifu_req_ready}, {31'd0, !own});
        chk("lsu_req_ready", {31'd0, lsu_req_ready}, {31'd0, own});
        m_last = own;
        ea  = own ? la : ia;
        ew  = own ? lw : 1'b0;
        em  = own ? lm : 4'hF;
        ewd = lwd;
        step();
        clr_inputs();
        for (int i = 0; i <= rdy_dly; i++) begin
            mem_req_ready = (i == rdy_dly);
            if (junk) begin
                ifu_req_valid  = 1'($urandom);
                lsu_req_valid  = 1'($urandom);
                mem_resp_valid = 1'($urandom);
                mem_rdata      = $urandom;
            end
            #1;
            chk("req_mem_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("req_mem_addr", mem_addr, ea);
            chk("req_mem_wen", {31'd0, mem_wen}, {31'd0, ew});
            chk("req_mem_wmask", {28'd0, mem_wmask}, {28'd0, em});
            if (own) chk("req_mem_wdata", mem_wdata, ewd);
            chk("req_busy_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
            step();
        end
        clr_inputs();
        if (resp_dly >= 0) begin
            for (int i = 0; i < resp_dly; i++) begin
                if (junk) begin
                    ifu_req_valid = 1'($urandom);
                    lsu_req_valid = 1'($urandom);
                end
                #1;
                chk("wait_mem_valid", {31'd0, mem_req_valid}, 32'd0);
                chk("wait_busy_ready",
                    {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
                chk("wait_no_resp",
                    {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
                step();
            end
            mem_resp_valid = 1'b1;
            mem_rdata      = rd;
            erd  = rd;
            eerr = 1'b0;
            step();
            clr_inputs();
        end else begin
            n = 0;
            while (!(ifu_resp_valid || lsu_resp_valid) && n < 400) begin
                n++;
                step();
            end
            chk("timeout_wait_cycles", n, 32'd255);
            erd  = 32'hDEAD_BEEF;
            eerr = 1'b1;
        end
        chk("resp_ifu_valid", {31'd0, ifu_resp_valid}, {31'd0, !own});
        chk("resp_lsu_valid", {31'd0, lsu_resp_valid}, {31'd0, own});
        if (own) begin
            m_lsu_rd = erd;
            chk("resp_lsu_err", {31'd0, lsu_resp_err}, {31'd0, eerr});
        end else begin
            m_ifu_rd = erd;
            chk("resp_ifu_err", {31'd0, ifu_resp_err}, {31'd0, eerr});
        end
        chk("resp_ifu_rdata", ifu_rdata, m_ifu_rd);
        chk("resp_lsu_rdata", lsu_rdata, m_lsu_rd);
        step();
        chk("post_resp_idle",
            {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    endtask

    initial begin
        int got;
        int gap;
        bit iv, lv;
        rst       = 1'b1;
        ifu_addr  = '0;
        lsu_addr  = '0;
        lsu_wen   = 1'b0;
        lsu_wdata = '0;
        lsu_wmask = '0;
        mem_rdata = '0;
        clr_inputs();

        tbl[0] = '{1'b1, 1'b1, 0, 32'h1111_0001};
        tbl[1] = '{1'b1, 1'b1, 1, 32'h2222_0002};
        tbl[2] = '{1'b1, 1'b1, 0, 32'h3333_0003};
        tbl[3] = '{1'b0, 1'b1, 1, 32'h4444_0004};
        tbl[4] = '{1'b1, 1'b0, 0, 32'h5555_0005};
        tbl[5] = '{1'b1, 1'b1, 1, 32'h6666_0006};
        tbl[6] = '{1'b0, 1'b1, 1, 32'h7777_0007};
        tbl[7] = '{1'b1, 1'b1, 0, 32'h8888_0008};

        step();
        do_reset();
        #1;
        chk_zero_outs("reset");
        chk("reset_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);

        // First fetch at minimum latency
        do_txn(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0,
               0, 0, 32'h0000_0413, 0, got);
        chk("first_owner", got, 32'd0);

        // Grant-order table from a fresh reset
        do_reset();
        foreach (tbl[k]) begin
            do_txn(tbl[k].iv, tbl[k].lv, 32'h8000_0100 + 32'(k * 4),
                   32'h8000_1000, 0, 32'h0, 4'hF,
                   0, 0, tbl[k].rd, 0, got);
            chk("tbl_owner", got, tbl[k].exp_owner);
        end

        // LSU write, memory stalls the request for 5 cycles
        do_txn(0, 1, 32'h0, 32'h8000_2000, 1, 32'h1234_5678, 4'b0011,
               5, 2, 32'hCAFE_0000, 0, got);
        chk("write_owner", got, 32'd1);

        // Memory never answers: abort with error data
        do_txn(1, 0, 32'h8000_0040, 32'h0, 0, 32'h0, 4'h0,
               0, -1, 32'h0, 0, got);
        chk("after_timeout_ready_owner", got, 32'd0);
        do_txn(1, 0, 32'h8000_0044, 32'h0, 0, 32'h0, 4'h0,
               0, 0, 32'h0000_0013, 0, got);

        // Reset while waiting, then a stray response
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0080;
        mem_req_ready = 1'b1;
        step();
        ifu_req_valid = 1'b0;
        step();
        mem_req_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst            = 1'b0;
        m_last         = 1'b1;
        m_ifu_rd       = '0;
        m_lsu_rd       = '0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hBAD0_BAD0;
        #1;
        chk_zero_outs("midrst");
        step();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_resp",
                {28'd0, ifu_resp_valid, lsu_resp_valid,
                 ifu_resp_err, lsu_resp_err}, 32'd0);
            step();
        end
        do_txn(1, 1, 32'h8000_0090, 32'h8000_1010, 0, 32'h0, 4'hF,
               0, 1, 32'h0000_0093, 0, got);
        chk("midrst_next_owner", got, 32'd0);

        // Randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            iv = 1'($urandom);
            lv = 1'($urandom);
            if (!iv && !lv) iv = 1'b1;
            do_txn(iv, lv, $urandom, $urandom, 1'($urandom), $urandom,
                   4'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)), $urandom, 1, got);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                #1;
                chk("gap_idle",
                    {28'd0, ifu_req_ready, lsu_req_ready,
                     ifu_resp_valid, lsu_resp_valid}, 32'd0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
